// File: rtl/seq_rec_pkg.sv
// seq_rec_pkg: shared mode constants and saturating increment for the sequence recogniser
package seq_rec_pkg;
  localparam int MODE_MEALY = 0;
  localparam int MODE_MOORE = 1;
  localparam int OVL_OFF = 0;
  localparam int OVL_ON = 1;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
    return (v >= max) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/seq_rec_window.sv
// seq_rec_window: bit window shift register and fill counter; ports clk/rst_n, shift/clear/restart controls, d_in, next-state win_nx/fill_nx
module seq_rec_window #(
  parameter int W = 3,
  parameter int FW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          shift,
  input  logic          clear,
  input  logic          restart,
  input  logic          d_in,
  output logic [W-1:0]  win_nx,
  output logic [FW-1:0] fill_nx
);
  logic [W-1:0]  window;
  logic [FW-1:0] fill;
  assign win_nx = {window[W-2:0], d_in};
  assign fill_nx = (fill == FW'(W)) ? fill : fill + FW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      window <= '0;
      fill <= '0;
    end else if (clear) begin
      window <= '0;
      fill <= '0;
    end else if (shift) begin
      window <= win_nx;
      fill <= restart ? '0 : fill_nx;
    end
endmodule

// File: rtl/seq_rec_param.sv
// seq_rec_param: parametrised serial pattern recogniser; ports clk/rst_n, en, clr, d_in in; d_out match pulse and saturating match_cnt out
module seq_rec_param
  import seq_rec_pkg::*;
#(
  parameter int                   PATTERN_W = 3,
  parameter logic [PATTERN_W-1:0] PATTERN   = 3'b111,
  parameter int                   MOORE     = MODE_MEALY,
  parameter int                   OVERLAP   = OVL_ON,
  parameter int                   CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             d_in,
  output logic             d_out,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int FW = $clog2(PATTERN_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [PATTERN_W-1:0] win_nx;
  logic [FW-1:0]        fill_nx;
  logic                 hit;
  if (PATTERN_W < 2 || CNT_W < 1) begin : g_bad_param
    $error("seq_rec_param: PATTERN_W must be >= 2 and CNT_W >= 1");
  end
  seq_rec_window #(.W(PATTERN_W), .FW(FW)) u_win (
    .clk(clk),
    .rst_n(rst_n),
    .shift(en & ~clr),
    .clear(clr),
    .restart(hit & (OVERLAP == OVL_OFF)),
    .d_in(d_in),
    .win_nx(win_nx),
    .fill_nx(fill_nx)
  );
  // en gates first so an X on d_in while idle cannot reach d_out
  assign hit = en & ~clr & (fill_nx == FW'(PATTERN_W)) & (win_nx == PATTERN);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) match_cnt <= '0;
    else if (clr) match_cnt <= '0;
    else if (hit) match_cnt <= CNT_W'(sat_inc(64'(match_cnt), 64'(CNT_MAX)));
  if (MOORE == MODE_MOORE) begin : g_moore
    logic d_q;
    // not cleared by clr: the pulse for a completed match still lands next cycle
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) d_q <= 1'b0;
      else d_q <= hit;
    assign d_out = d_q;
  end else begin : g_mealy
    assign d_out = hit;
  end
endmodule

// File: tb/tb_seq_rec_param.sv
// tb_seq_rec_param: scoreboard bench for four seq_rec_param configurations against a bit-history reference model
module tb_seq_rec_param;
  typedef struct packed {
    logic [3:0]      hit;
    logic [3:0][7:0] cnt;
  } exp_t;
  logic clk = 0, rst_n = 0, en = 0, clr = 0, d_in = 0;
  logic [3:0] dout;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;
  logic [7:0] ca [4];
  int tests = 0, fails = 0;
  exp_t q[$];
  bit hist [4][$];
  int cnt [4] = '{0, 0, 0, 0};
  int w [4] = '{3, 3, 4, 4};
  int pat [4] = '{7, 7, 11, 11};
  int ovl [4] = '{1, 0, 1, 0};
  int cmax [4] = '{255, 255, 255, 3};
  always #5 clk = ~clk;
  assign ca[0] = c0;
  assign ca[1] = c1;
  assign ca[2] = c2;
  assign ca[3] = {6'b0, c3};
  seq_rec_param #(.PATTERN_W(3), .PATTERN(3'b111), .MOORE(0), .OVERLAP(1), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d_in(d_in), .d_out(dout[0]), .match_cnt(c0));
  seq_rec_param #(.PATTERN_W(3), .PATTERN(3'b111), .MOORE(0), .OVERLAP(0), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d_in(d_in), .d_out(dout[1]), .match_cnt(c1));
  seq_rec_param #(.PATTERN_W(4), .PATTERN(4'b1011), .MOORE(1), .OVERLAP(1), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d_in(d_in), .d_out(dout[2]), .match_cnt(c2));
  seq_rec_param #(.PATTERN_W(4), .PATTERN(4'b1011), .MOORE(1), .OVERLAP(0), .CNT_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d_in(d_in), .d_out(dout[3]), .match_cnt(c3));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input bit e, input bit c, input bit d, input bit r);
    exp_t x;
    bit m;
    @(negedge clk);
    if (r) begin
      rst_n = 0;
      #1;
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
        hist[i].delete();
        cnt[i] = 0;
      end
    end
    en = e;
    clr = c;
    d_in = e ? d : 1'bx;
    x = '0;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        hist[i].delete();
        cnt[i] = 0;
      end else if (e) begin
        hist[i].push_back(d);
        if (hist[i].size() > w[i]) void'(hist[i].pop_front());
        if (hist[i].size() == w[i]) begin
          m = 1;
          for (int k = 0; k < w[i]; k++) if (hist[i][k] != pat[i][w[i]-1-k]) m = 0;
          x.hit[i] = m;
        end
        if (x.hit[i]) begin
          if (cnt[i] < cmax[i]) cnt[i]++;
          if (ovl[i] == 0) hist[i].delete();
        end
      end
      x.cnt[i] = 8'(cnt[i]);
    end
    q.push_back(x);
  endtask
  task automatic feed(input logic [31:0] bits, input int n);
    logic [31:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) step(1, 0, b[i], 0);
  endtask
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        chk("mealy_ovl_dout", 32'(dout[0]), 32'(q[0].hit[0]));
        chk("mealy_novl_dout", 32'(dout[1]), 32'(q[0].hit[1]));
      end
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("moore_ovl_dout", 32'(dout[2]), 32'(x.hit[2]));
        chk("moore_novl_dout", 32'(dout[3]), 32'(x.hit[3]));
        for (int i = 0; i < 4; i++) chk($sformatf("match_cnt%0d", i), 32'(ca[i]), 32'(x.cnt[i]));
      end
    end
  end
  initial begin : stim
    #3;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_dout%0d", i), 32'(dout[i]), 32'd0);
      chk($sformatf("reset_cnt%0d", i), 32'(ca[i]), 32'd0);
    end
    #4 rst_n = 1;
    feed(32'b0111110, 7);
    feed(32'b111, 3);
    step(1, 1, 0, 0);
    feed(32'b1011011, 7);
    step(0, 1, 0, 0);
    feed(32'b11, 2);
    repeat (3) step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    step(0, 1, 0, 0);
    feed(32'b11, 2);
    step(1, 0, 1, 1);
    feed(32'b11, 2);
    step(0, 1, 0, 0);
    feed(32'b11, 2);
    step(1, 1, 1, 0);
    repeat (6) feed(32'b1011, 4);
    for (int i = 0; i < 1500; i++)
      step($urandom % 4 != 0, $urandom % 40 == 0, $urandom % 4 != 0, $urandom % 150 == 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
